arbiter_grant_hold: RTL
=======================

ARBITER_GRANT_HOLD -- requirements
Module: arbiter_grant_hold

Interface
REQ-001 SHALL have parameter CLIENTS, default 4: number of arbitrated clients, >=2.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum HOLD cycles waiting for ack, >=2.
REQ-003 SHALL have localparam IW = $clog2(CLIENTS) and CW = $clog2(TIMEOUT)+1.
REQ-004 i_clk  input  1  clock, all state rising-edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_gnt  input  CLIENTS  registered one-hot grant from the round-robin arbiter.
REQ-007 i_ack  input  CLIENTS  per-client transfer-complete, sampled only in HOLD.
REQ-008 o_block_arb  output  1  combinational, drives the arbiter's block input.
REQ-009 o_gnt_hold  output  CLIENTS  registered one-hot grant held until release.
REQ-010 o_gnt_id  output  IW  registered binary index of held client.
REQ-011 o_gnt_valid  output  1  registered, high while o_gnt_hold nonzero.
REQ-012 o_timeout  output  1  registered one-cycle pulse, hold ended without ack.
REQ-013 o_err  output  1  registered one-cycle pulse, illegal grant seen.

Function
REQ-014 SHALL implement FSM IDLE, HOLD, RELEASE, encoded in a registered state.
REQ-015 o_block_arb SHALL equal (state != IDLE) OR (|i_gnt), so the arbiter issues no new grant after the captured one.
REQ-016 IDLE, i_gnt one-hot at cycle T: capture; at T+1 state=HOLD, o_gnt_hold=i_gnt, o_gnt_id=index, o_gnt_valid=1, counter=0.
REQ-017 IDLE, i_gnt zero: remain IDLE; i_ack ignored.
REQ-018 IDLE, i_gnt with >1 bit set: no capture, remain IDLE, o_err pulses at T+1.
REQ-019 HOLD: counter increments by 1 each cycle without ack, saturating at TIMEOUT-1.
REQ-020 HOLD, i_ack[o_gnt_id]=1: next state RELEASE; i_ack on other bits ignored.
REQ-021 HOLD, no valid ack and counter==TIMEOUT-1: next state RELEASE, o_timeout pulses next cycle.
REQ-022 Valid ack in the same cycle as the timeout condition SHALL win: no o_timeout.
REQ-023 Entering RELEASE SHALL clear o_gnt_hold, o_gnt_valid; o_gnt_id holds last value.
REQ-024 RELEASE lasts exactly one cycle (arbiter still blocked), then IDLE.
REQ-025 Nonzero i_gnt while in HOLD or RELEASE SHALL be ignored and pulse o_err next cycle.
REQ-026 Max hold = TIMEOUT cycles; ack at HOLD cycle k (0-based) -> o_gnt_hold low at k+1 after its rise.
REQ-027 Grant-to-next-grant minimum turnaround: capture, >=1 HOLD, RELEASE, IDLE = 3 cycles.

Reset
REQ-028 Asserting i_rst_n low SHALL asynchronously force state=IDLE, counter=0, o_gnt_hold=0, o_gnt_id=0, o_gnt_valid=0, o_timeout=0, o_err=0.
REQ-029 Reset mid-HOLD SHALL drop the held grant without o_timeout; o_block_arb then follows i_gnt only.
REQ-030 After deassertion, the first rising edge SHALL evaluate IDLE rules.

Verification
REQ-031 CLIENTS=4: i_gnt=4'b0100 one cycle, i_ack[2]=1 three cycles later -> o_gnt_hold=0100, id=2 for 3 cycles, RELEASE 1 cycle, o_block_arb high from grant cycle through RELEASE.
REQ-032 TIMEOUT=16: i_gnt=0001, no ack -> o_gnt_hold high exactly 16 cycles, o_timeout single pulse on the cycle it clears.
REQ-033 i_gnt=0001 held, i_ack=0010 (wrong client) -> ignored, ends by timeout; then ack on cycle 15 together -> no o_timeout.
REQ-034 i_gnt=0110 in IDLE -> o_err pulse, o_gnt_valid stays 0; i_gnt=1000 during HOLD -> o_err pulse, held grant unchanged.
REQ-035 i_rst_n pulsed low mid-HOLD -> all outputs 0 immediately, no o_timeout; next i_gnt=0010 captured normally.
REQ-036 Integrated with arbiter_round_robin, all 4 requesting, immediate acks -> grants rotate, never two held simultaneously.

Source files
------------

// File: rtl/arbiter_grant_hold.sv
// Grant-hold stage behind a round-robin arbiter.
// It captures a one-hot registered grant and holds it until the granted client
// acks, or until a bounded timeout expires. While it holds, it blocks the arbiter.
//
// Handshake: there is no valid/ready pair here. A grant is offered on i_gnt for
// one cycle and accepted only in IDLE. It counts only if exactly one bit is set.
// The hold is released by the held client's i_ack, which is sampled only in HOLD.
// Acks from any other client are ignored.
module arbiter_grant_hold #(
   parameter  int CLIENTS = 4,
   parameter  int TIMEOUT = 16,
   localparam int IW      = $clog2(CLIENTS),
   localparam int CW      = $clog2(TIMEOUT) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [CLIENTS-1:0] i_gnt,
   input  logic [CLIENTS-1:0] i_ack,
   output logic               o_block_arb,
   output logic [CLIENTS-1:0] o_gnt_hold,
   output logic [IW-1:0]      o_gnt_id,
   output logic               o_gnt_valid,
   output logic               o_timeout,
   output logic               o_err,
   output logic [1:0]         o_dbg_state
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CLIENTS-1:0] GNT_ONE  = {{(CLIENTS-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CLIENTS-1:0] r_gnt_hold;
   logic [IW-1:0]      r_gnt_id;
   logic               r_gnt_valid;
   logic               r_timeout;
   logic               r_err;

   logic               w_gnt_any;
   logic               w_gnt_onehot;
   logic [CLIENTS-1:0] w_gnt_dec;
   logic [IW-1:0]      w_gnt_idx;
   logic               w_ack_hit;
   logic               w_cnt_last;
   logic               w_release;

   assign w_gnt_any    = |i_gnt;
   assign w_gnt_dec    = i_gnt - GNT_ONE;
   // A nonzero vector is one-hot when clearing its lowest set bit leaves zero.
   assign w_gnt_onehot = w_gnt_any && ((i_gnt & w_gnt_dec) == '0);
   assign w_ack_hit    = i_ack[r_gnt_id];
   assign w_cnt_last   = (r_cnt == CNT_LAST);
   // The hold ends on the held client's ack or on the last allowed cycle.
   // When both happen in the same cycle, the ack wins.
   assign w_release    = w_ack_hit || w_cnt_last;

   // The arbiter stays blocked from the grant cycle itself until we are back in IDLE.
   assign o_block_arb  = (r_state != S_IDLE) || w_gnt_any;

   assign o_gnt_hold   = r_gnt_hold;
   assign o_gnt_id     = r_gnt_id;
   assign o_gnt_valid  = r_gnt_valid;
   assign o_timeout    = r_timeout;
   assign o_err        = r_err;
   assign o_dbg_state  = r_state;

   // Binary index of the incoming grant. It is only used when the grant is one-hot.
   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         if (i_gnt[i]) w_gnt_idx = IW'(i);
      end
   end

   // Next-state logic: IDLE -> HOLD on a legal grant, HOLD -> RELEASE, RELEASE -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_gnt_onehot) w_state_nxt = S_HOLD;
         S_HOLD:    if (w_release)    w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Held grant, index and hold-cycle counter.
   // The index is kept through RELEASE for debug visibility.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gnt_hold  <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_onehot) begin
                  r_gnt_hold  <= i_gnt;
                  r_gnt_id    <= w_gnt_idx;
                  r_gnt_valid <= 1'b1;
                  r_cnt       <= '0;
               end
            end
            S_HOLD: begin
               if (w_release) begin
                  r_gnt_hold  <= '0;
                  r_gnt_valid <= 1'b0;
               end else if (!w_cnt_last) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_gnt_hold  <= '0;
               r_gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   // Single-cycle status pulses.
   // Timeout fires when the hold expires without an ack.
   // Error fires on any grant that cannot be accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_timeout <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_timeout <= (r_state == S_HOLD) && w_cnt_last && !w_ack_hit;
         r_err     <= (r_state == S_IDLE) ? (w_gnt_any && !w_gnt_onehot) : w_gnt_any;
      end
   end

endmodule
